serial_pattern_tx: RTL and testbench

Moore-style parallel-to-serial pattern transmitter that drives the single-bit serial line `w` consumed by our serial sequence detectors.
- Captures a pattern word and a bit count on Start.
- Emits the pattern MSB-first, one bit per Clock, with Valid framing.
- Pulses Done after the last bit.
- Used in the lab datapath and in benches to generate detector stimulus such as "1001" and "1111".

---
 rtl/serial_pattern_tx.sv | 91 +++++++++
 tb/tb_serial_pattern_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial pattern transmitter: sends Data[L-1:0] MSB-first on w with
// Valid framing, then pulses Done for one cycle. All outputs decode registered state.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int LW    = 5
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data,
    input  logic [LW-1:0]    Len,
    input  logic             Abort,
    output logic             w,
    output logic             Valid,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg;
    logic [LW-1:0]    cnt;
    logic [LW-1:0]    eff_len;
    logic             load;

    // Over-long requests are clamped to the register width rather than rejected.
    assign eff_len = (Len > WIDTH_L) ? WIDTH_L : Len;
    assign load    = (state == IDLE) && Start && !Abort && (eff_len != '0);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        w         = 1'b0;
        Valid     = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        state_dbg = state;
        case (state)
            IDLE: begin
                if (load) state_nx = SHIFT;
            end
            SHIFT: begin
                w     = sreg[WIDTH-1];
                Valid = 1'b1;
                Busy  = 1'b1;
                if (Abort) begin
                    state_nx = IDLE;
                end else if (cnt == ONE_L) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                Busy     = 1'b1;
                Done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Left-align the pattern so the bit to send is always at the MSB.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= Data << (WIDTH_L - eff_len);
            cnt  <= eff_len;
        end else if (state == SHIFT) begin
            sreg <= sreg << 1;
            cnt  <= cnt - ONE_L;
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: driver pushes cycle-stamped expected bits/Done
// into a queue; a negedge monitor pops and compares whenever Valid or Done is seen.
module tb_serial_pattern_tx;

    logic       Clock;
    logic       Resetn;
    logic       Start;
    logic [7:0] Data;
    logic [4:0] Len;
    logic       Abort;
    logic       w;
    logic       Valid;
    logic       Busy;
    logic       Done;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected event: {cycle[15:0], is_done, bit}
    logic [17:0] exp_q[$];
    logic [17:0] mon_got;
    logic [17:0] mon_exp;

    serial_pattern_tx #(.WIDTH(8), .LW(5)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Start    (Start),
        .Data     (Data),
        .Len      (Len),
        .Abort    (Abort),
        .w        (w),
        .Valid    (Valid),
        .Busy     (Busy),
        .Done     (Done),
        .state_dbg(state_dbg)
    );

    // Clock / reset block
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [17:0] ev(input int c, input logic is_done, input logic b);
        return {c[15:0], is_done, b};
    endfunction

    // Reference model: an accepted frame starting at edge after cycle n yields
    // bit i of the clamped pattern at cycle n+1+i and Done at n+1+L.
    task automatic push_frame(input int n, input logic [7:0] d, input int l, input int nbits,
                              input bit with_done);
        for (int i = 0; i < nbits; i++) exp_q.push_back(ev(n + 1 + i, 1'b0, d[l-1-i]));
        if (with_done) exp_q.push_back(ev(n + 1 + l, 1'b1, 1'b0));
    endtask

    // Scoreboard monitor
    always @(negedge Clock) begin
        while (exp_q.size() > 0 && int'(exp_q[0][17:2]) < (cyc & 16'hFFFF)) begin
            mon_exp = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missed_event: got=none expected=%0h (cycle %0d)", mon_exp, cyc);
        end
        if (Valid || Done) begin
            mon_got = ev(cyc, Done, w);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got=%0h expected=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("serial_event", 32'(mon_got), 32'(mon_exp));
            end
        end
        chk("busy_framing", 32'(Busy), 32'(Valid || Done));
        if (!Valid) chk("idle_line_zero", 32'(w), 32'd0);
    end

    // Driver tasks
    task automatic send_frame(input logic [7:0] d, input logic [4:0] ln, input int abort_k,
                              input bit dabort, input bit dstart);
        int l;
        int n;
        l = (ln > 5'd8) ? 8 : int'(ln);
        @(negedge Clock);
        n = cyc;
        Start = 1'b1; Data = d; Len = ln; Abort = 1'b0;
        if (l > 0) push_frame(n, d, l, (abort_k > 0) ? abort_k : l, abort_k == 0);
        @(negedge Clock);
        Start = 1'b0; Data = 8'($urandom); Len = 5'($urandom);
        if (l == 0) return;
        if (abort_k > 0) begin
            repeat (abort_k - 1) @(negedge Clock);
            Abort = 1'b1;
            @(negedge Clock);
            Abort = 1'b0;
            return;
        end
        repeat (l) @(negedge Clock);
        Abort = dabort; Start = dstart;
        @(negedge Clock);
        Abort = 1'b0; Start = 1'b0;
    endtask

    task automatic idle_start_abort();
        @(negedge Clock);
        Start = 1'b1; Abort = 1'b1; Data = 8'($urandom); Len = 5'($urandom_range(1, 8));
        @(negedge Clock);
        Start = 1'b0; Abort = 1'b0;
    endtask

    task automatic held_start();
        int n;
        @(negedge Clock);
        n = cyc;
        Start = 1'b1; Data = 8'h0F; Len = 5'd4; Abort = 1'b0;
        push_frame(n, 8'h0F, 4, 4, 1'b1);
        push_frame(n + 6, 8'h0F, 4, 4, 1'b1);
        for (int j = 1; j <= 12; j++) begin
            @(negedge Clock);
            if (j == 2) Data = 8'hF0;
            if (j == 5) Data = 8'h0F;
            if (j == 7) begin Start = 1'b0; Data = 8'h00; end
        end
    endtask

    task automatic reset_mid_frame();
        int n;
        @(negedge Clock);
        n = cyc;
        Start = 1'b1; Data = 8'hFF; Len = 5'd8; Abort = 1'b0;
        push_frame(n, 8'hFF, 8, 3, 1'b0);
        @(negedge Clock);
        Start = 1'b0;
        repeat (2) @(negedge Clock);
        #2 Resetn = 1'b0;
        #1;
        chk("rst_w", 32'(w), 32'd0);
        chk("rst_valid", 32'(Valid), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
    endtask

    initial begin
        Resetn = 1'b0; Start = 1'b0; Data = '0; Len = '0; Abort = 1'b0;
        #1;
        chk("init_w", 32'(w), 32'd0);
        chk("init_valid", 32'(Valid), 32'd0);
        chk("init_busy", 32'(Busy), 32'd0);
        chk("init_done", 32'(Done), 32'd0);
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;

        send_frame(8'b0000_1001, 5'd4, 0, 1'b0, 1'b0);
        send_frame(8'hA5, 5'd8, 0, 1'b0, 1'b0);
        send_frame(8'hA5, 5'd20, 0, 1'b0, 1'b0);
        send_frame(8'hA5, 5'd0, 0, 1'b0, 1'b0);
        send_frame(8'hA5, 5'd1, 0, 1'b0, 1'b0);
        held_start();
        send_frame(8'hFF, 5'd8, 3, 1'b0, 1'b0);
        send_frame(8'h5A, 5'd6, 0, 1'b1, 1'b0);
        send_frame(8'h3C, 5'd5, 0, 1'b0, 1'b1);
        idle_start_abort();
        reset_mid_frame();
        send_frame(8'b0000_1111, 5'd4, 0, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [7:0] d;
            logic [4:0] ln;
            int         l;
            int         ak;
            d  = 8'($urandom);
            ln = 5'($urandom_range(0, 20));
            l  = (ln > 5'd8) ? 8 : int'(ln);
            ak = 0;
            if (l >= 2 && $urandom_range(0, 4) == 0) ak = $urandom_range(1, l - 1);
            if ($urandom_range(0, 5) == 0) idle_start_abort();
            send_frame(d, ln, ak, 1'($urandom), 1'($urandom));
        end

        repeat (5) @(negedge Clock);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
